seq_mult16: RTL and testbench



---
 rtl/seq_mult16.sv | 122 ++++++++++++
 tb/tb_seq_mult16.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult16.sv
// Multi-cycle shift-add multiplier: one WIDTH-bit add per clock, 2*WIDTH-bit product.
// Optional signed mode via `define SIGNED_MULT_EN (adds signed_op port and a NEG state).
module seq_mult16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
`ifdef SIGNED_MULT_EN
  input  logic               signed_op,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEG} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_p;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_p_next;
  logic [WIDTH-1:0]   w_mc_in;
  logic [WIDTH-1:0]   w_mp_in;

  // carry-out of the add becomes the new MSB of the shifted partial product
  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
  assign w_p_next = r_p[0] ? {w_sum, r_p[WIDTH-1:1]} : {1'b0, r_p[2*WIDTH-1:1]};

`ifdef SIGNED_MULT_EN
  logic r_sop;
  logic r_sign;
  assign w_mc_in = (signed_op && mcand[WIDTH-1])  ? (~mcand  + WIDTH'(1)) : mcand;
  assign w_mp_in = (signed_op && mplier[WIDTH-1]) ? (~mplier + WIDTH'(1)) : mplier;
`else
  assign w_mc_in = mcand;
  assign w_mp_in = mplier;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_p       <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
`ifdef SIGNED_MULT_EN
      r_sop     <= 1'b0;
      r_sign    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_m     <= w_mc_in;
            r_p     <= {{WIDTH{1'b0}}, w_mp_in};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef SIGNED_MULT_EN
            r_sop   <= signed_op;
            r_sign  <= signed_op & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
`endif
          end
          S_RUN: begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
`ifdef SIGNED_MULT_EN
              if (r_sop) begin
                r_state <= S_NEG;
              end else begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_product <= w_p_next;
              end
`else
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_product <= w_p_next;
`endif
            end
          end
          S_NEG: begin
`ifdef SIGNED_MULT_EN
            r_product <= r_sign ? (~r_p + (2*WIDTH)'(1)) : r_p;
`endif
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult16.sv
// Directed + randomized bench for seq_mult16; expected products come from plain arithmetic.
module tb_seq_mult16;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           flush = 1'b0;
  logic           signed_op = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  seq_mult16 #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .flush(flush),
    .mcand(mcand),
    .mplier(mplier),
`ifdef SIGNED_MULT_EN
    .signed_op(signed_op),
`endif
    .busy(busy),
    .done(done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sop);
    longint sa, sb;
    longint ua, ub;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a[W-1]) ? ua - 65536 : ua;
    sb = (b[W-1]) ? ub - 65536 : ub;
`ifdef SIGNED_MULT_EN
    if (sop) return (2*W)'(sa * sb);
`else
    if (sop) return (2*W)'(sa * sb);  // never requested when the port is absent
`endif
    return (2*W)'(ua * ub);
  endfunction

  // Caller is at a negedge; start is driven for the following posedge (edge 0).
  // mode 1: re-drive start with 2*2 for the edge numbered 'at' (must be ignored).
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop,
                          input int mode, input int at, input string tag);
    int cyc;
    int lat;
    bit busy_ok;
    logic [2*W-1:0] exp;
    exp = model(a, b, sop);
    lat = W + (sop ? 1 : 0);
    start = 1'b1; mcand = a; mplier = b; signed_op = sop;
    cyc = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (mode == 1 && cyc == at) begin start = 1'b1; mcand = 16'h2; mplier = 16'h2; end
      if (mode == 1 && cyc == at + 1) start = 1'b0;
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && cyc < 40);
    check({tag, "_latency"}, 64'(cyc), 64'(lat + 1));
    check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_product"}, 64'(product), 64'(exp));
  endtask

  initial begin
    bit seen_done;
    logic [W-1:0] ra, rb;

    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_mult(16'h0003, 16'h0005, 1'b0, 0, 0, "small");
    run_mult(16'hFFFF, 16'hFFFF, 1'b0, 0, 0, "max");
    // started in the done cycle of the previous op: zero-bubble back-to-back
    run_mult(16'h1234, 16'h0010, 1'b0, 0, 0, "b2b");
    @(negedge clk);
    check("done_pulse_clears", 64'(done), 64'd0);

    run_mult(16'h00FF, 16'h0101, 1'b0, 1, 3, "ignored_start");

    // flush mid-run: no done, product keeps the last completed value
    run_mult(16'h0003, 16'h0005, 1'b0, 0, 0, "pre_flush");
    start = 1'b1; mcand = 16'h0010; mplier = 16'h0010;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    seen_done = 1'b0;
    repeat (20) begin @(negedge clk); if (done) seen_done = 1'b1; end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_product", 64'(product), 64'h0000000F);

    // flush and start together: start is dropped
    start = 1'b1; flush = 1'b1; mcand = 16'h0009; mplier = 16'h0009;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check("flush_beats_start", 64'(busy), 64'd0);

    // asynchronous reset between edges while running
    start = 1'b1; mcand = 16'h1111; mplier = 16'h2222;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_product", 64'(product), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    run_mult(16'h0007, 16'h0006, 1'b0, 0, 0, "after_rst");

    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i == 0) rb = 16'h0000;
      if (i == 1) ra = 16'h8000;
      run_mult(ra, rb, 1'b0, 0, 0, "rand_u");
    end

`ifdef SIGNED_MULT_EN
    run_mult(16'hFFFD, 16'h0005, 1'b1, 0, 0, "signed_neg3x5");
    run_mult(16'h8000, 16'h8000, 1'b1, 0, 0, "signed_minmin");
    run_mult(16'hFFFD, 16'h0005, 1'b0, 0, 0, "signed_op0");
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_mult(ra, rb, 1'b1, 0, 0, "rand_s");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
